// File: rtl/score_row_maxsub.sv
`default_nettype none
// ============================================================================
//  Module      : score_row_maxsub
//  Description : Softmax pre-stage. Buffers one score row (ROW_BEATS beats per
//                lane), tracks the per-lane row maximum while filling, then
//                replays the row as sat(element - row_max), which is always
//                <= 0 and clamped to the most negative WIDTH_OUT value.
//                A single row buffer alternates between a fill phase and a
//                drain phase.
//  Ports       : clk, rst (asynchronous, active-high)
//                in_data  [TOTAL_INPUT_W][VB]   in_valid / in_ready
//                out_data [TOTAL_INPUT_W][VB]   out_valid / out_ready / out_last
//                out_row_max [TOTAL_INPUT_W][WIDTH_OUT]  (ROW_MAX_PORT_EN only)
//                Element e of a lane sits at [VB-1-e*WIDTH_OUT -: WIDTH_OUT].
//  Options     : `define ROW_MAX_PORT_EN adds the out_row_max port.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_row_maxsub #(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    parameter int TOTAL_INPUT_W = 2,
    parameter int ROW_BEATS     = 4,
    localparam int EPV = CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
    localparam int VB  = WIDTH_OUT * EPV
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [TOTAL_INPUT_W-1:0][VB-1:0]        in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [TOTAL_INPUT_W-1:0][VB-1:0]        out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last
`ifdef ROW_MAX_PORT_EN
    ,
    output logic [TOTAL_INPUT_W-1:0][WIDTH_OUT-1:0] out_row_max
`endif
);

    localparam int PTR_W = $clog2(ROW_BEATS) + 1;
    // Buffer index width; a single-beat buffer still needs a one-bit index.
    localparam int IDX_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

    localparam logic [PTR_W-1:0]            c_LAST     = PTR_W'(ROW_BEATS - 1);
    localparam logic signed [WIDTH_OUT-1:0] c_ELEM_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    localparam logic signed [WIDTH_OUT:0]   c_DIFF_MIN = {2'b11, {(WIDTH_OUT-1){1'b0}}};

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                          r_state;
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [PTR_W-1:0]                r_rd_ptr;
    logic signed [WIDTH_OUT-1:0]     r_max      [TOTAL_INPUT_W];
    logic signed [WIDTH_OUT-1:0]     w_max_next [TOTAL_INPUT_W];
    logic [TOTAL_INPUT_W-1:0][VB-1:0] r_buf     [ROW_BEATS];
    logic [TOTAL_INPUT_W-1:0][VB-1:0] w_rd_beat;
    logic signed [WIDTH_OUT:0]       w_diff;
    logic [IDX_W-1:0]                w_wr_idx;
    logic [IDX_W-1:0]                w_rd_idx;
    logic                            w_fill_acc;
    logic                            w_drain_acc;

    assign in_ready    = (r_state == S_FILL);
    assign out_valid   = (r_state == S_DRAIN);
    assign out_last    = out_valid && (r_rd_ptr == c_LAST);
    assign w_fill_acc  = in_ready && in_valid;
    assign w_drain_acc = out_valid && out_ready;
    assign w_wr_idx    = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx    = r_rd_ptr[IDX_W-1:0];
    assign w_rd_beat   = r_buf[w_rd_idx];

    // Running maximum folded with every signed element of the incoming beat.
    always_comb begin
        for (int l = 0; l < TOTAL_INPUT_W; l++) begin
            w_max_next[l] = r_max[l];
            for (int e = 0; e < EPV; e++) begin
                if ($signed(in_data[l][VB-1-e*WIDTH_OUT -: WIDTH_OUT]) > w_max_next[l]) begin
                    w_max_next[l] = in_data[l][VB-1-e*WIDTH_OUT -: WIDTH_OUT];
                end
            end
        end
    end

    // Output path is fed only by the row buffer, the max registers and the
    // read pointer, so it holds steady for free while the consumer stalls.
    // The subtraction is done one bit wider so that e.g. -2^(W-1) - (2^(W-1)-1)
    // clamps instead of wrapping to +1.
    always_comb begin
        out_data = '0;
        w_diff   = '0;
        for (int l = 0; l < TOTAL_INPUT_W; l++) begin
            for (int e = 0; e < EPV; e++) begin
                w_diff = {w_rd_beat[l][VB-1-e*WIDTH_OUT],
                          w_rd_beat[l][VB-1-e*WIDTH_OUT -: WIDTH_OUT]}
                       - {r_max[l][WIDTH_OUT-1], r_max[l]};
                if (out_valid) begin
                    out_data[l][VB-1-e*WIDTH_OUT -: WIDTH_OUT] =
                        (w_diff < c_DIFF_MIN) ? c_ELEM_MIN : w_diff[WIDTH_OUT-1:0];
                end
            end
        end
    end

`ifdef ROW_MAX_PORT_EN
    always_comb begin
        for (int l = 0; l < TOTAL_INPUT_W; l++) begin
            out_row_max[l] = out_valid ? r_max[l] : '0;
        end
    end
`endif

    // Row storage carries no reset; its contents are only read after a
    // complete fill.
    always_ff @(posedge clk) begin
        if (w_fill_acc) begin
            r_buf[w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int l = 0; l < TOTAL_INPUT_W; l++) begin
                r_max[l] <= c_ELEM_MIN;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_fill_acc) begin
                        for (int l = 0; l < TOTAL_INPUT_W; l++) begin
                            r_max[l] <= w_max_next[l];
                        end
                        if (r_wr_ptr == c_LAST) begin
                            r_wr_ptr <= '0;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_acc) begin
                        if (r_rd_ptr == c_LAST) begin
                            r_rd_ptr <= '0;
                            r_state  <= S_FILL;
                            for (int l = 0; l < TOTAL_INPUT_W; l++) begin
                                r_max[l] <= c_ELEM_MIN;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_row_maxsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_row_maxsub
//  Description : Self-checking bench for score_row_maxsub. Rows are generated
//                directed or with $urandom; expected drain beats come from a
//                plain-integer model (row max over all elements, then
//                max(elem - max, -2^(W-1))).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_row_maxsub;

    localparam int W   = 16;
    localparam int EPV = 4 * 4 * 1 * 2;
    localparam int VB  = W * EPV;
    localparam int TI  = 2;
    localparam int RB  = 4;

    typedef logic [TI-1:0][VB-1:0] beat_t;

    logic  clk = 1'b0;
    logic  rst;
    beat_t in_data;
    logic  in_valid;
    logic  in_ready;
    beat_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;
`ifdef ROW_MAX_PORT_EN
    logic [TI-1:0][W-1:0] out_row_max;
`endif

    always #5 clk = ~clk;

    score_row_maxsub #(
        .WIDTH_OUT    (W),
        .CHUNK_SIZE   (4),
        .NUM_CORES_A  (4),
        .NUM_CORES_B  (1),
        .TOTAL_MODULES(2),
        .TOTAL_INPUT_W(TI),
        .ROW_BEATS    (RB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
`ifdef ROW_MAX_PORT_EN
        ,
        .out_row_max(out_row_max)
`endif
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t cur_row [RB];
    beat_t exp_row [RB];
    int    exp_max [TI];

    task automatic chk(input string tag, input logic [VB-1:0] got, input logic [VB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        logic [TI*VB-1:0] f;
        for (int k = 0; k < TI*VB/32; k++) f[k*32 +: 32] = $urandom;
        return beat_t'(f);
    endfunction

    task automatic set_elem(input int b, input int l, input int e, input logic [W-1:0] v);
        cur_row[b][l][VB-1-e*W -: W] = v;
    endtask

    // Reference: whole-row maximum per lane, then clamped differences.
    task automatic build_exp();
        int m, v, d;
        logic [W-1:0] s;
        for (int l = 0; l < TI; l++) begin
            m = -32768;
            for (int b = 0; b < RB; b++)
                for (int e = 0; e < EPV; e++) begin
                    s = cur_row[b][l][VB-1-e*W -: W];
                    v = int'($signed(s));
                    if (v > m) m = v;
                end
            exp_max[l] = m;
            for (int b = 0; b < RB; b++)
                for (int e = 0; e < EPV; e++) begin
                    s = cur_row[b][l][VB-1-e*W -: W];
                    d = int'($signed(s)) - m;
                    if (d < -32768) d = -32768;
                    exp_row[b][l][VB-1-e*W -: W] = 16'(d);
                end
        end
    endtask

    // mode 0: full-range random, mode 1: small values around zero
    task automatic gen_row(input int mode);
        int v;
        for (int b = 0; b < RB; b++)
            for (int l = 0; l < TI; l++)
                for (int e = 0; e < EPV; e++) begin
                    if (mode == 0) v = int'($urandom_range(0, 65535));
                    else           v = int'($urandom_range(0, 400)) - 200;
                    set_elem(b, l, e, 16'(v));
                end
    endtask

    task automatic fill_row(input bit bubbles);
        build_exp();
        for (int b = 0; b < RB; b++) begin
            if (bubbles && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_data  = rand_beat();
                chk("fill_idle_valid", out_valid, 1'b0);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = cur_row[b];
            chk($sformatf("fill_ready b%0d", b), in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // rmode 0: always ready, 1: pattern 1,0,0,1, 2: random
    task automatic drain_row(input int rmode, input bit junk, input int abort_at);
        int idx = 0;
        int cyc = 0;
        bit r;
        while (idx < RB && cyc < 64) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = rand_beat();
            end
            chk($sformatf("drain_valid b%0d", idx), out_valid, 1'b1);
            chk($sformatf("drain_in_ready b%0d", idx), in_ready, 1'b0);
            chk($sformatf("drain_last b%0d", idx), out_last, (idx == RB-1));
            for (int l = 0; l < TI; l++) begin
                chk($sformatf("data b%0d l%0d", idx, l), out_data[l], exp_row[idx][l]);
`ifdef ROW_MAX_PORT_EN
                chk($sformatf("row_max l%0d", l), out_row_max[l], 16'(exp_max[l]));
`endif
            end
            if (idx == abort_at) return;
            @(posedge clk); #1;
            if (r) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_complete", (idx == RB), 1'b1);
        chk("back_to_fill_ready", in_ready, 1'b1);
        chk("back_to_fill_valid", out_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data_l0", out_data[0], '0);
        chk("rst_out_data_l1", out_data[1], '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ascending 0..127 in lane 0
        gen_row(0);
        for (int b = 0; b < RB; b++)
            for (int e = 0; e < EPV; e++) set_elem(b, 0, e, 16'(b*EPV + e));
        fill_row(1'b0);
        chk("t1_first_elem", out_data[0][VB-1 -: W], 16'hFF81);
        drain_row(0, 1'b0, -1);

        // All -16, then all +5: max must be re-initialised between rows
        for (int b = 0; b < RB; b++)
            for (int l = 0; l < TI; l++)
                for (int e = 0; e < EPV; e++) set_elem(b, l, e, 16'hFFF0);
        fill_row(1'b0);
        drain_row(0, 1'b0, -1);
        for (int b = 0; b < RB; b++)
            for (int l = 0; l < TI; l++)
                for (int e = 0; e < EPV; e++) set_elem(b, l, e, 16'h0005);
        fill_row(1'b0);
        drain_row(0, 1'b0, -1);

        // Saturation: single 7FFF among 8000
        for (int b = 0; b < RB; b++)
            for (int l = 0; l < TI; l++)
                for (int e = 0; e < EPV; e++) set_elem(b, l, e, 16'h8000);
        set_elem(2, 0, 7, 16'h7FFF);
        set_elem(0, 1, 31, 16'h7FFF);
        fill_row(1'b0);
        drain_row(0, 1'b0, -1);

        // Back-pressure pattern 1,0,0,1
        gen_row(0);
        fill_row(1'b0);
        drain_row(1, 1'b0, -1);

        // in_valid held high with junk through the drain, then a fresh row
        gen_row(1);
        fill_row(1'b0);
        drain_row(2, 1'b1, -1);
        gen_row(1);
        fill_row(1'b0);
        drain_row(0, 1'b0, -1);

        // Random rows with bubbles and random back-pressure
        for (int n = 0; n < 16; n++) begin
            gen_row(n % 2);
            fill_row(1'b1);
            drain_row(2, n[2], -1);
        end

        // Reset after two accepted drain beats
        gen_row(0);
        fill_row(1'b0);
        drain_row(0, 1'b0, 2);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_last", out_last, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        gen_row(1);
        fill_row(1'b0);
        drain_row(0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
